// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit side: the byte width used on every
// data path and the state encoding of the arbiter that shares one uart_tx
// between several requesters.
// Ports: none (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Arbiter FSM encoding, kept as plain constants so older tools can read it.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the uart_tx handshake seen by the
// arbiter.
//   req       : one bit per requester, high while a byte is pending
//   req_data  : requester i byte on [8i+7:8i]
//   req_ack   : one-hot single-cycle accept pulse
//   tx_enable : single-cycle start strobe towards uart_tx
//   tx_data   : byte towards uart_tx
//   tx_busy   : busy flag coming back from uart_tx
// master = arbiter side, slave = requesters plus uart_tx side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    import uart_pkg::*;

    logic [NREQ-1:0]             req;
    logic [UART_DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]             req_ack;
    logic                        tx_enable;
    logic [UART_DATA_W-1:0]      tx_data;
    logic                        tx_busy;

    modport master (
        input  req, req_data, tx_busy,
        output req_ack, tx_enable, tx_data
    );

    modport slave (
        output req, req_data, tx_busy,
        input  req_ack, tx_enable, tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
//   i_req     : request vector
//   i_last    : index of the previous winner
//   o_winner  : first requester with a high bit, searching upward from
//               i_last+1 and wrapping from NREQ-1 to 0 (holds i_last if idle)
//   o_any_req : at least one request bit is high
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [$clog2(NREQ)-1:0] o_winner,
    output logic                    o_any_req
);

    localparam int GW = $clog2(NREQ);

    logic          w_found;
    logic [GW-1:0] w_idx;

    // Walk the NREQ positions after i_last in order; the modulo keeps the
    // wrap correct when NREQ is not a power of two. The last position tried
    // is i_last itself, so a lone repeat requester still wins.
    always_comb begin
        o_winner  = i_last;
        o_any_req = |i_req;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                o_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NREQ requesters with round-robin arbitration.
//   clk           : system clock, rising edge
//   reset         : synchronous active-high reset
//   bus           : requester / uart_tx handshake (master modport)
//   o_grant_id    : index of the most recently granted requester
//   o_active      : high whenever the FSM is not idle
//   o_err_timeout : one-cycle pulse when tx_busy never rose after an issue
//   o_err_count   : saturating count of those timeouts
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_arbiter_if.master       bus,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_active,
    output logic                    o_err_timeout,
    output logic [7:0]              o_err_count
);

    localparam int GW = $clog2(NREQ);
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    logic [1:0]      r_state;
    logic            r_txEnable;
    logic [NREQ-1:0] r_reqAck;
    uart_byte_t      r_txData;
    logic [GW-1:0]   r_grantId;
    logic            r_active;
    logic            r_errTimeout;
    logic [7:0]      r_errCount;
    logic [TW-1:0]   r_timer;

    logic [GW-1:0]   w_winner;
    logic            w_anyReq;
    uart_byte_t      w_winData;
    logic [NREQ-1:0] w_winOneHot;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req     (bus.req),
        .i_last    (r_grantId),
        .o_winner  (w_winner),
        .o_any_req (w_anyReq)
    );

    // Decode the winner into its data byte and its one-hot ack pattern with
    // constant-index loops so no variable part-select is needed.
    always_comb begin
        w_winData   = '0;
        w_winOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_winData      = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
                w_winOneHot[i] = 1'b1;
            end
        end
    end

    // Main FSM. The strobes are loaded on the IDLE->ISSUE transition so they
    // are high exactly while the FSM sits in ISSUE, one cycle after the
    // request was sampled. Once acked the byte is considered consumed, so a
    // timeout returns to IDLE without re-sending it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_txEnable   <= 1'b0;
            r_reqAck     <= '0;
            r_txData     <= '0;
            r_grantId    <= GW'(NREQ - 1);
            r_active     <= 1'b0;
            r_errTimeout <= 1'b0;
            r_errCount   <= '0;
            r_timer      <= '0;
        end else begin
            r_txEnable   <= 1'b0;
            r_reqAck     <= '0;
            r_errTimeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq && !bus.tx_busy) begin
                        r_txData   <= w_winData;
                        r_grantId  <= w_winner;
                        r_txEnable <= 1'b1;
                        r_reqAck   <= w_winOneHot;
                        r_active   <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (bus.tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end else if (r_timer == TW'(BUSY_TIMEOUT - 1)) begin
                        r_errTimeout <= 1'b1;
                        r_errCount   <= satInc8(r_errCount);
                        r_active     <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        r_active <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_enable  = r_txEnable;
    assign bus.req_ack    = r_reqAck;
    assign bus.tx_data    = r_txData;
    assign o_grant_id     = r_grantId;
    assign o_active       = r_active;
    assign o_err_timeout  = r_errTimeout;
    assign o_err_count    = r_errCount;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed, table-driven bench for uart_tx_arbiter (NREQ=4, BUSY_TIMEOUT=4).
// The bench plays every requester and the uart_tx busy flag.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ         = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grantId;
    logic       active;
    logic       errTimeout;
    logic [7:0] errCount;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .o_grant_id    (grantId),
        .o_active      (active),
        .o_err_timeout (errTimeout),
        .o_err_count   (errCount)
    );

    always #5 clk = ~clk;

    int nVectors     = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          busyLen;
        logic [3:0]  expAck;
        logic [1:0]  expGrant;
        logic [7:0]  expData;
        logic        expTimeout;
        logic [7:0]  expErrCount;
    } vec_t;

    vec_t vecs [8];

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Compare every output against its post-reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_enable"}, 32'(bus.tx_enable), 32'd0);
        checkOutput({tag, "_req_ack"},   32'(bus.req_ack),   32'd0);
        checkOutput({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
        checkOutput({tag, "_err_to"},    32'(errTimeout),    32'd0);
        checkOutput({tag, "_err_count"}, 32'(errCount),      32'd0);
        checkOutput({tag, "_active"},    32'(active),        32'd0);
        checkOutput({tag, "_grant_id"},  32'(grantId),       32'd3);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transfer: present req/data, capture the issue cycle, answer with a
    // busy pulse of busyLen cycles starting 3 cycles after issue (busyLen=0
    // means busy never rises), and return once the arbiter is idle again.
    task automatic applyStimulus(input logic [3:0] reqV, input logic [31:0] dataV,
                                 input int busyLen, input bit holdReq,
                                 output logic [3:0] ackSeen, output logic [1:0] grantSeen,
                                 output logic [7:0] dataSeen, output int enCount,
                                 output int toCount);
        int issueAt = -1;
        bit done    = 1'b0;
        ackSeen   = '0;
        grantSeen = '0;
        dataSeen  = '0;
        enCount   = 0;
        toCount   = 0;
        bus.req      = reqV;
        bus.req_data = dataV;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus.tx_enable) begin
                enCount++;
                if (issueAt < 0) begin
                    issueAt   = i;
                    ackSeen   = bus.req_ack;
                    grantSeen = grantId;
                    dataSeen  = bus.tx_data;
                    if (!holdReq) bus.req = '0;
                end
            end
            if (errTimeout) toCount++;
            if (issueAt >= 0 && i > issueAt && !active) done = 1'b1;
            else if (issueAt >= 0 && busyLen > 0)
                bus.tx_busy = (i >= issueAt + 3) && (i < issueAt + 3 + busyLen);
        end
        checkOutput("txn_complete", 32'(done), 32'd1);
        bus.tx_busy = 1'b0;
    endtask

    logic [3:0] ack;
    logic [1:0] g;
    logic [7:0] d;
    int         en;
    int         to;
    int         totalTo;
    bit         seen;

    initial begin
        // Expected values assume grant_id=3 after reset, so the search starts
        // at requester 0; each row's winner follows from the previous row.
        vecs[0] = '{4'b0100, 32'h44A52211, 10, 4'b0100, 2'd2, 8'hA5, 1'b0, 8'd0};
        vecs[1] = '{4'b1111, 32'hD3C2B1A0,  2, 4'b1000, 2'd3, 8'hD3, 1'b0, 8'd0};
        vecs[2] = '{4'b1111, 32'hD3C2B1A0,  2, 4'b0001, 2'd0, 8'hA0, 1'b0, 8'd0};
        vecs[3] = '{4'b0110, 32'h00665500,  1, 4'b0010, 2'd1, 8'h55, 1'b0, 8'd0};
        vecs[4] = '{4'b0010, 32'h00007700,  0, 4'b0010, 2'd1, 8'h77, 1'b1, 8'd1};
        vecs[5] = '{4'b1001, 32'h99000088,  4, 4'b1000, 2'd3, 8'h99, 1'b0, 8'd1};
        vecs[6] = '{4'b1001, 32'h99000088,  0, 4'b0001, 2'd0, 8'h88, 1'b1, 8'd2};
        vecs[7] = '{4'b0101, 32'h00CC00BB,  5, 4'b0100, 2'd2, 8'hCC, 1'b0, 8'd2};

        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;

        // Reset values.
        doReset();
        checkResetValues("reset");

        // Table of single transfers.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].req, vecs[v].data, vecs[v].busyLen, 1'b0, ack, g, d, en, to);
            checkOutput($sformatf("v%0d_ack", v),       32'(ack),       32'(vecs[v].expAck));
            checkOutput($sformatf("v%0d_grant", v),     32'(g),         32'(vecs[v].expGrant));
            checkOutput($sformatf("v%0d_data", v),      32'(d),         32'(vecs[v].expData));
            checkOutput($sformatf("v%0d_en_count", v),  32'(en),        32'd1);
            checkOutput($sformatf("v%0d_timeout", v),   32'(to),        32'(vecs[v].expTimeout));
            checkOutput($sformatf("v%0d_err_count", v), 32'(errCount),  32'(vecs[v].expErrCount));
            checkOutput($sformatf("v%0d_data_held", v), 32'(bus.tx_data), 32'(vecs[v].expData));
        end

        // Timeout counter saturation: 2 timeouts so far plus 300 more.
        totalTo = 0;
        for (int n = 0; n < 300; n++) begin
            applyStimulus(4'b0010, 32'h0000EE00, 0, 1'b0, ack, g, d, en, to);
            totalTo += to;
        end
        checkOutput("sat_pulses",    32'(totalTo),  32'd300);
        checkOutput("sat_err_count", 32'(errCount), 32'd255);
        checkOutput("sat_last_ack",  32'(ack),      32'b0010);

        // Reset while waiting for busy to fall.
        bus.req = 4'b0001;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_enable) begin
                seen        = 1'b1;
                bus.tx_busy = 1'b1;
                bus.req     = '0;
            end
        end
        checkOutput("midrst_issue", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("midrst_active", 32'(active), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midrst");
        reset       = 1'b0;
        bus.tx_busy = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_issue", 32'(bus.tx_enable), 32'd0);

        applyStimulus(4'b1000, 32'h5A000000, 2, 1'b0, ack, g, d, en, to);
        checkOutput("post_rst_grant", 32'(g),   32'd3);
        checkOutput("post_rst_ack",   32'(ack), 32'b1000);
        checkOutput("post_rst_data",  32'(d),   32'h5A);

        // Fairness with every requester pending continuously.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(4'b1111, 32'h44332211, 2, 1'b1, ack, g, d, en, to);
            checkOutput($sformatf("fair%0d_grant", n), 32'(g),   32'(n % 4));
            checkOutput($sformatf("fair%0d_ack", n),   32'(ack), 32'(1 << (n % 4)));
            checkOutput($sformatf("fair%0d_data", n),  32'(d),   32'(8'h11 * ((n % 4) + 1)));
        end
        bus.req = '0;

        // Busy held from reset blocks the issue until it falls.
        bus.tx_busy = 1'b1;
        doReset();
        bus.req      = 4'b0001;
        bus.req_data = 32'h000000C3;
        en = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_enable) en++;
        end
        checkOutput("block_no_issue", 32'(en), 32'd0);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        checkOutput("block_issue", 32'(bus.tx_enable), 32'd1);
        checkOutput("block_ack",   32'(bus.req_ack),   32'b0001);
        checkOutput("block_data",  32'(bus.tx_data),   32'hC3);
        bus.req = '0;
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        bus.tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (!active) seen = 1'b1;
        end
        checkOutput("block_idle",      32'(seen),     32'd1);
        checkOutput("block_err_count", 32'(errCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit, want run complete");
        $fatal(1, "[TB] run did not complete");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL be the number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 4, SHALL be the number of cycles to wait for tx_busy to rise after issue.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  bit i high: requester i has a byte pending.
REQ-006 req_data  input  8*NREQ  requester i byte on [8i+7:8i].
REQ-007 req_ack  output  NREQ  one-hot, one-cycle pulse: requester i byte accepted.
REQ-008 tx_enable  output  1  one-cycle strobe to uart_tx.
REQ-009 tx_data  output  8  byte to uart_tx; held stable between issues.
REQ-010 tx_busy  input  1  busy flag from uart_tx.
REQ-011 grant_id  output  clog2(NREQ)  index of most recently granted requester.
REQ-012 active  output  1  high in any state other than IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT.
REQ-014 err_count  output  8  saturating count of timeouts.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-016 IDLE: when any req bit is high and tx_busy=0, the block SHALL select winner g, latch req_data[g] into tx_data, set grant_id=g and go to ISSUE.
REQ-017 Otherwise IDLE SHALL hold, with no outputs changed.
REQ-018 Arbitration SHALL be round-robin: search starts at (grant_id+1) mod NREQ, and the first high req bit wins.
REQ-019 ISSUE (exactly 1 cycle): tx_enable=1 and req_ack[g]=1 SHALL be asserted, then the FSM SHALL go to WAIT_HI.
REQ-020 Latency: req sampled high in IDLE at cycle N SHALL give tx_enable/req_ack at cycle N+1.
REQ-021 WAIT_HI: tx_busy=1 SHALL move the FSM to WAIT_LO.
REQ-022 WAIT_HI: after BUSY_TIMEOUT cycles without tx_busy, the FSM SHALL pulse err_timeout, increment err_count (saturating at 255) and return to IDLE.
REQ-023 WAIT_LO: tx_busy=0 SHALL return the FSM to IDLE; there is no timeout in WAIT_LO.
REQ-024 Requesters SHALL hold req and req_data stable until req_ack.
REQ-025 The byte latched at grant SHALL be sent even if req falls after grant.
REQ-026 req is ignored outside IDLE, so a requester may present its next byte the cycle after ack.
REQ-027 Back-to-back: minimum spacing between tx_enable strobes SHALL be 4 cycles plus the busy period.
REQ-028 tx_enable and req_ack SHALL never be high outside ISSUE.
REQ-029 At most one req_ack bit SHALL be high in any cycle.
REQ-030 A timeout SHALL NOT re-send the byte; it is considered consumed (already acked).
REQ-031 NREQ not a power of two: the round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-032 On reset: state=IDLE, tx_enable=0, req_ack=0, tx_data=0, err_timeout=0, err_count=0, active=0, grant_id=NREQ-1 (so requester 0 has first priority).
REQ-033 Reset asserted in any state SHALL take effect at the next rising edge; an in-flight ISSUE SHALL be dropped, and no ack is generated after the reset edge.

Structure
REQ-034 Shared package uart_pkg SHALL hold the UART data width constant (8) and the arbiter FSM state encoding.
REQ-035 The round-robin winner selection SHALL be a separate combinational sub-module, rr_pick (inputs: request vector, last grant; outputs: winner index, any_req).
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Single request: req=4'b0100, data[2]=8'hA5, tx_busy pulses high 3 cycles after issue for 10 cycles -> one ack[2] at N+1, tx_data=8'hA5, tx_enable once, grant_id=2, return to IDLE after busy falls.
REQ-038 Fairness: req=4'b1111 held permanently with an ideal uart_tx model -> grant order 0,1,2,3,0,... and each requester acked once per 4 transfers.
REQ-039 Busy blocking: tx_busy=1 held from reset, req=4'b0001 -> no tx_enable until tx_busy falls, then issue the following cycle.
REQ-040 Timeout: tx_busy tied 0, req=4'b0010 -> ack[1], err_timeout pulse after 4 WAIT_HI cycles, err_count=1; after 300 such transfers err_count=255.
REQ-041 Reset mid-transfer: reset asserted in WAIT_LO -> all outputs at reset values next cycle; after release with req=4'b1000, first grant is requester 3 and the next grant with all requests high is 0.
